// File: rtl/fp34_pkg.sv
// Shared definitions for the 34-bit extended FP32 format: exn tag, sign, biased exponent, fraction.
package fp34_pkg;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  localparam int EXN_HI   = 33;
  localparam int EXN_LO   = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;
  localparam int FRAC_LO  = 0;

  localparam logic [33:0] FP34_POS_ZERO_NORM = 34'h100000000;

  typedef struct packed {
    logic [1:0]  exn;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp34_t;

  // exn 1x covers both inf and NaN
  function automatic logic is_special(input logic [1:0] exn);
    return exn[1];
  endfunction

endpackage

// File: rtl/leakyrelu_fp32.sv
// Combinational LeakyReLU with alpha = 2^-ALPHA_SHIFT, applied by exponent decrement only.
module leakyrelu_fp32
  import fp34_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2
) (
  input  logic [33:0] X,
  output logic [33:0] Y
);

  localparam logic [7:0] SHIFT8 = 8'(ALPHA_SHIFT);

  fp34_t xf;
  assign xf = fp34_t'(X);

  always_comb begin
    Y = X;
    if (xf.exn == EXN_NORM && xf.sign) begin
      if (xf.exp > SHIFT8) begin
        Y[EXP_HI:EXP_LO] = xf.exp - SHIFT8;
      end else begin
        // Too small to scale: flush to negative zero rather than build a subnormal
        Y = {EXN_ZERO, 1'b1, 31'd0};
      end
    end
  end

endmodule

// File: rtl/relu_fp32.sv
// Combinational ReLU on the 34-bit format; negative finite values become canonical +0.
module relu_fp32
  import fp34_pkg::*;
(
  input  logic [33:0] X,
  output logic [33:0] Y
);

  fp34_t xf;
  assign xf = fp34_t'(X);

  always_comb begin
    Y = X;
    if (!is_special(xf.exn) && xf.sign) begin
      Y = FP34_POS_ZERO_NORM;
    end
  end

endmodule

// File: rtl/activation_fp32.sv
// Registered ReLU and LeakyReLU of one operand per accepted cycle, single-cycle latency.
module activation_fp32
  import fp34_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [33:0] x,
  output logic        out_valid,
  output logic [33:0] y_relu,
  output logic [33:0] y_leaky
);

  logic [33:0] relu_comb;
  logic [33:0] leaky_comb;

  relu_fp32 u_relu (
    .X (x),
    .Y (relu_comb)
  );

  leakyrelu_fp32 #(
    .ALPHA_SHIFT (ALPHA_SHIFT)
  ) u_leaky (
    .X (x),
    .Y (leaky_comb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y_relu    <= '0;
      y_leaky   <= '0;
    end else begin
      out_valid <= in_valid;
      // Data holds while idle; out_valid alone qualifies it
      if (in_valid) begin
        y_relu  <= relu_comb;
        y_leaky <= leaky_comb;
      end
    end
  end

endmodule

// File: tb/tb_activation_fp32.sv
// Directed bench for activation_fp32 with hand-computed expected values.
module tb_activation_fp32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [33:0] x;
  logic        out_valid;
  logic [33:0] y_relu;
  logic [33:0] y_leaky;

  int checks;
  int errors;

  activation_fp32 #(.ALPHA_SHIFT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .out_valid (out_valid),
    .y_relu    (y_relu),
    .y_leaky   (y_leaky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one valid operand, then check the registered results after the edge
  task automatic apply(input string tag, input logic [33:0] xv,
                       input logic [33:0] exp_relu, input logic [33:0] exp_leaky);
    @(negedge clk);
    in_valid = 1'b1;
    x = xv;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 34'(out_valid), 34'd1);
    check({tag, "_relu"}, y_relu, exp_relu);
    check({tag, "_leaky"}, y_leaky, exp_leaky);
    $display("txn %s x=%h relu=%h leaky=%h valid=%0d", tag, xv, y_relu, y_leaky, out_valid);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    x = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 34'(out_valid), 34'd0);
    check("rst_relu", y_relu, 34'd0);
    check("rst_leaky", y_leaky, 34'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_valid", 34'(out_valid), 34'd0);

    apply("pos_one", 34'h13f800000, 34'h13f800000, 34'h13f800000);
    apply("neg_one", 34'h1bf800000, 34'h100000000, 34'h1be800000);
    apply("pos_zero_norm", 34'h100000000, 34'h100000000, 34'h100000000);
    apply("neg_zero", 34'h080000000, 34'h100000000, 34'h080000000);
    apply("pos_zero_exn0", 34'h000000000, 34'h000000000, 34'h000000000);
    apply("nan", 34'h300000001, 34'h300000001, 34'h300000001);
    apply("neg_inf", 34'h280000000, 34'h280000000, 34'h280000000);
    apply("uflow_e1", 34'h180800000, 34'h100000000, 34'h080000000);
    apply("uflow_e2", 34'h181000000, 34'h100000000, 34'h080000000);
    apply("scale_e3", 34'h181800000, 34'h100000000, 34'h180800000);
    apply("frac_keep", 34'h1c0123456, 34'h100000000, 34'h1bf123456);

    // Idle cycle: valid drops, data holds the last result
    @(negedge clk);
    in_valid = 1'b0;
    x = 34'h1bf800000;
    @(posedge clk);
    #1;
    check("hold_valid", 34'(out_valid), 34'd0);
    check("hold_relu", y_relu, 34'h100000000);
    check("hold_leaky", y_leaky, 34'h1bf123456);
    $display("txn hold relu=%h leaky=%h valid=%0d", y_relu, y_leaky, out_valid);

    // Four back-to-back operands
    apply("stream0", 34'h140000000, 34'h140000000, 34'h140000000);
    apply("stream1", 34'h1c0000000, 34'h100000000, 34'h1bf000000);
    apply("stream2", 34'h2ffffffff, 34'h2ffffffff, 34'h2ffffffff);
    apply("stream3", 34'h1bf400000, 34'h100000000, 34'h1be400000);

    // Reset mid-stream, between edges
    @(negedge clk);
    in_valid = 1'b1;
    x = 34'h13f800000;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 34'(out_valid), 34'd0);
    check("arst_relu", y_relu, 34'd0);
    check("arst_leaky", y_leaky, 34'd0);
    $display("txn async_reset relu=%h leaky=%h valid=%0d", y_relu, y_leaky, out_valid);
    @(posedge clk);
    #1;
    check("inrst_valid", 34'(out_valid), 34'd0);
    check("inrst_relu", y_relu, 34'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 34'(out_valid), 34'd0);
    check("post_rst_relu", y_relu, 34'd0);
    check("post_rst_leaky", y_leaky, 34'd0);
    $display("txn post_reset relu=%h leaky=%h valid=%0d", y_relu, y_leaky, out_valid);

    apply("after_rst", 34'h1bf800000, 34'h100000000, 34'h1be800000);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("final_valid", 34'(out_valid), 34'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
